// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the fetch and memory stages.
// One transaction is outstanding at a time. Data requests win arbitration unless
// the instruction side has already lost STARVE_LIMIT grants in a row.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    output logic          i_ok,
    output logic [DW-1:0] i_data,
    input  logic          d_valid,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [2:0]    d_size,
    input  logic [3:0]    d_strobe,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ok,
    output logic [DW-1:0] d_data,
    output logic          m_valid,
    output logic          m_write,
    output logic [AW-1:0] m_addr,
    output logic [2:0]    m_size,
    output logic [3:0]    m_strobe,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic          m_ok,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state;
    logic       grant_d;
    logic [2:0] streak;
    logic       ok_fire;
    logic       pick_d;

    // Data wins unless the fetch side is pending and has hit its starvation limit.
    always_comb begin
        pick_d = d_valid && !(i_valid && (streak == LIMIT));
    end

    // Completion is combinational with m_ok; suppressed in reset and outside a transaction.
    always_comb begin
        ok_fire = resetn && (((state == ISSUE) && m_ready && m_ok) ||
                             ((state == WAIT) && m_ok));
        i_ok    = ok_fire && !grant_d;
        d_ok    = ok_fire && grant_d;
        i_data  = m_rdata;
        d_data  = m_rdata;
    end

    // Arbitration FSM with registered bus request fields and starvation streak.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            grant_d  <= 1'b0;
            streak   <= '0;
            m_valid  <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_size   <= '0;
            m_strobe <= '0;
            m_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        grant_d  <= 1'b1;
                        m_valid  <= 1'b1;
                        m_write  <= d_write;
                        m_addr   <= d_addr;
                        m_size   <= d_size;
                        m_strobe <= d_strobe;
                        m_wdata  <= d_wdata;
                        state    <= ISSUE;
                        if (!i_valid) begin
                            streak <= '0;
                        end else if (streak != LIMIT) begin
                            streak <= streak + 3'd1;
                        end
                    end else if (i_valid) begin
                        grant_d  <= 1'b0;
                        m_valid  <= 1'b1;
                        m_write  <= 1'b0;
                        m_addr   <= i_addr;
                        m_size   <= 3'd2;
                        m_strobe <= '0;
                        m_wdata  <= '0;
                        streak   <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= m_ok ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (m_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
